// File: rtl/battle_turn_ctrl_pkg.sv
// Shared definitions for the battle turn sequencer and damage calculator:
// FSM state encodings, roll codes and datapath widths.
package battle_turn_ctrl_pkg;

    localparam int MOVE_W = 4;
    localparam int ROLL_W = 2;
    localparam int DMG_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_P_ROLL = 2'd1,
        ST_E_ROLL = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [ROLL_W-1:0] ROLL_MISS   = 2'd0;
    localparam logic [ROLL_W-1:0] ROLL_HIT    = 2'd1;
    localparam logic [ROLL_W-1:0] ROLL_STRONG = 2'd2;
    localparam logic [ROLL_W-1:0] ROLL_CRIT   = 2'd3;

endpackage

// File: rtl/battle_dmg_calc.sv
// Combinational damage from a base move value and a 2-bit roll.
// Also used by the enemy-AI block, so it carries no state of its own.
module battle_dmg_calc
    import battle_turn_ctrl_pkg::*;
(
    input  logic [MOVE_W-1:0] base,
    input  logic [ROLL_W-1:0] roll,
    output logic [DMG_W-1:0]  dmg
);

    always_comb begin
        dmg = '0;
        case (roll)
            ROLL_MISS:   dmg = '0;
            ROLL_HIT:    dmg = DMG_W'(base);
            ROLL_STRONG: dmg = DMG_W'(base) + DMG_W'(base >> 1);
            ROLL_CRIT:   dmg = DMG_W'({base, 1'b0});
            default:     dmg = '0;
        endcase
    end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Turn sequencer: player roll, enemy counter-roll, HP bookkeeping, win/lose.
// Optional feature macro BATTLE_HEAL_EN turns player move type 0 into a heal.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a player move; lfsr_type parked at 0
// P_ROLL  | player's move shown to the LFSR; roll applied to enemy_hp
// E_ROLL  | enemy's move shown to the LFSR; roll applied to player_hp
// DONE    | someone reached 0 HP; frozen until reset
module battle_turn_ctrl
    import battle_turn_ctrl_pkg::*;
#(
    parameter int HP_W      = 8,
    parameter int MAX_HP    = 100,
    parameter int ROLL_WAIT = 1,
    parameter int HEAL_AMT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    input  logic [MOVE_W-1:0] move_type,
    input  logic [ROLL_W-1:0] roll_state,
    output logic [MOVE_W-1:0] lfsr_type,
    output logic              lfsr_is_player,
    output logic              busy,
    output logic [HP_W-1:0]   player_hp,
    output logic [HP_W-1:0]   enemy_hp,
    output logic              game_over,
    output logic              player_won
);

    localparam int WAIT_W = (ROLL_WAIT > 1) ? $clog2(ROLL_WAIT) : 1;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [1:0]        turn_cnt, turn_nx;
    logic [MOVE_W-1:0] type_nx;
    logic              is_player_nx, busy_nx, over_nx, won_nx;
    logic [HP_W-1:0]   player_hp_nx, enemy_hp_nx;
    logic [HP_W-1:0]   enemy_hp_hit, player_hp_hit;
    logic [MOVE_W-1:0] enemy_type;
    logic [DMG_W-1:0]  dmg;
    logic              roll_due;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [DMG_W-1:0] d);
        logic [HP_W:0] d_x;
        d_x = (HP_W+1)'(d);
        if ({1'b0, hp} <= d_x) sat_sub = '0;
        else                   sat_sub = hp - d_x[HP_W-1:0];
    endfunction

    // lfsr_type always holds the move type of the half-turn in progress,
    // so one calculator serves both sides.
    battle_dmg_calc u_dmg (
        .base (lfsr_type),
        .roll (roll_state),
        .dmg  (dmg)
    );

    assign enemy_type    = MOVE_W'(turn_cnt) + MOVE_W'(1);
    assign roll_due      = (wait_cnt == WAIT_W'(ROLL_WAIT - 1));
    assign enemy_hp_hit  = sat_sub(enemy_hp, dmg);
    assign player_hp_hit = sat_sub(player_hp, dmg);

`ifdef BATTLE_HEAL_EN
    logic [HP_W:0]   heal_sum;
    logic [HP_W-1:0] player_hp_heal;
    assign heal_sum       = {1'b0, player_hp} + (HP_W+1)'(HEAL_AMT);
    assign player_hp_heal = (heal_sum > (HP_W+1)'(MAX_HP)) ? HP_W'(MAX_HP)
                                                           : heal_sum[HP_W-1:0];
`else
    logic unused_heal;
    assign unused_heal = |HEAL_AMT;
`endif

    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        turn_nx      = turn_cnt;
        type_nx      = lfsr_type;
        is_player_nx = lfsr_is_player;
        busy_nx      = busy;
        player_hp_nx = player_hp;
        enemy_hp_nx  = enemy_hp;
        over_nx      = game_over;
        won_nx       = player_won;
        case (state)
            ST_IDLE: begin
                if (move_valid && !game_over) begin
                    state_nx     = ST_P_ROLL;
                    type_nx      = move_type;
                    is_player_nx = 1'b1;
                    busy_nx      = 1'b1;
                    wait_nx      = '0;
                end
            end
            ST_P_ROLL: begin
                if (!roll_due) begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end else begin
                    wait_nx = '0;
`ifdef BATTLE_HEAL_EN
                    if (lfsr_type == '0) begin
                        player_hp_nx = player_hp_heal;
                        state_nx     = ST_E_ROLL;
                        type_nx      = enemy_type;
                        is_player_nx = 1'b0;
                    end else
`endif
                    begin
                        enemy_hp_nx = enemy_hp_hit;
                        if (enemy_hp_hit == '0) begin
                            state_nx = ST_DONE;
                            won_nx   = 1'b1;
                            over_nx  = 1'b1;
                            busy_nx  = 1'b0;
                            type_nx  = '0;
                        end else begin
                            state_nx     = ST_E_ROLL;
                            type_nx      = enemy_type;
                            is_player_nx = 1'b0;
                        end
                    end
                end
            end
            ST_E_ROLL: begin
                if (!roll_due) begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end else begin
                    wait_nx      = '0;
                    player_hp_nx = player_hp_hit;
                    busy_nx      = 1'b0;
                    type_nx      = '0;
                    if (player_hp_hit == '0) begin
                        state_nx = ST_DONE;
                        won_nx   = 1'b0;
                        over_nx  = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                        turn_nx  = turn_cnt + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                over_nx = 1'b1;
                busy_nx = 1'b0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            turn_cnt       <= '0;
            lfsr_type      <= '0;
            lfsr_is_player <= 1'b0;
            busy           <= 1'b0;
            player_hp      <= HP_W'(MAX_HP);
            enemy_hp       <= HP_W'(MAX_HP);
            game_over      <= 1'b0;
            player_won     <= 1'b0;
        end else begin
            state          <= state_nx;
            wait_cnt       <= wait_nx;
            turn_cnt       <= turn_nx;
            lfsr_type      <= type_nx;
            lfsr_is_player <= is_player_nx;
            busy           <= busy_nx;
            player_hp      <= player_hp_nx;
            enemy_hp       <= enemy_hp_nx;
            game_over      <= over_nx;
            player_won     <= won_nx;
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl (default parameters, ROLL_WAIT=1).
// Expected HP values are worked out by hand from the damage table.
module tb_battle_turn_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic [3:0] move_type;
    logic [1:0] roll_state;
    logic [3:0] lfsr_type;
    logic       lfsr_is_player;
    logic       busy;
    logic [7:0] player_hp;
    logic [7:0] enemy_hp;
    logic       game_over;
    logic       player_won;

    int n_cmp = 0;
    int n_bad = 0;

    battle_turn_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .move_valid     (move_valid),
        .move_type      (move_type),
        .roll_state     (roll_state),
        .lfsr_type      (lfsr_type),
        .lfsr_is_player (lfsr_is_player),
        .busy           (busy),
        .player_hp      (player_hp),
        .enemy_hp       (enemy_hp),
        .game_over      (game_over),
        .player_won     (player_won)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        move_valid = 1'b0;
        move_type  = 4'd0;
        roll_state = 2'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Full turn: accept (E0), player roll (E1), enemy roll (E2).
    task automatic do_turn(input logic [3:0] mt, input logic [1:0] pr,
                           input logic [1:0] er);
        move_valid = 1'b1;
        move_type  = mt;
        roll_state = pr;
        tick();
        move_valid = 1'b0;
        tick();
        roll_state = er;
        tick();
    endtask

    initial begin
        do_reset();

        // reset state
        chk("rst_php", player_hp, 100);
        chk("rst_ehp", enemy_hp, 100);
        chk("rst_busy", busy, 0);
        chk("rst_type", lfsr_type, 0);
        chk("rst_over", game_over, 0);
        chk("rst_isp", lfsr_is_player, 0);

        // move 4, roll hit both halves
        move_valid = 1'b1; move_type = 4'd4; roll_state = 2'd1;
        tick();
        move_valid = 1'b0;
        chk("e0_busy", busy, 1);
        chk("e0_type", lfsr_type, 4);
        chk("e0_isp", lfsr_is_player, 1);
        tick();
        chk("e1_ehp", enemy_hp, 96);
        chk("e1_type", lfsr_type, 1);
        chk("e1_isp", lfsr_is_player, 0);
        chk("e1_php", player_hp, 100);
        tick();
        chk("e2_php", player_hp, 99);
        chk("e2_busy", busy, 0);
        chk("e2_type", lfsr_type, 0);

        // move_valid held during a turn: ignored until busy has fallen
        do_reset();
        move_valid = 1'b1; move_type = 4'd4; roll_state = 2'd1;
        tick();
        move_type = 4'd15;
        tick();
        chk("bsy_ehp", enemy_hp, 96);
        tick();
        chk("bsy_php", player_hp, 99);
        chk("bsy_fall", busy, 0);
        roll_state = 2'd0;
        tick();
        move_valid = 1'b0;
        chk("bsy_next", busy, 1);
        chk("bsy_ntype", lfsr_type, 15);
        tick();
        chk("bsy_miss_e", enemy_hp, 96);
        chk("bsy_etype2", lfsr_type, 2);
        tick();
        chk("bsy_miss_p", player_hp, 99);
        tick();
        chk("bsy_idle", busy, 0);

        // crit 15 every roll: enemy 70,40,10,0; player 98,94,88
        do_reset();
        for (int t = 0; t < 3; t++) begin
            do_turn(4'd15, 2'd3, 2'd3);
        end
        chk("crit_ehp3", enemy_hp, 10);
        chk("crit_php3", player_hp, 88);
        move_valid = 1'b1; move_type = 4'd15; roll_state = 2'd3;
        tick();
        move_valid = 1'b0;
        tick();
        chk("win_ehp", enemy_hp, 0);
        chk("win_over", game_over, 1);
        chk("win_won", player_won, 1);
        chk("win_busy", busy, 0);
        tick();
        chk("win_php", player_hp, 88);

        // move requests after game over
        move_valid = 1'b1; move_type = 4'd15;
        tick();
        tick();
        move_valid = 1'b0;
        tick();
        chk("go_busy", busy, 0);
        chk("go_php", player_hp, 88);
        chk("go_over", game_over, 1);

        // reset while in P_ROLL drops the turn
        do_reset();
        move_valid = 1'b1; move_type = 4'd15; roll_state = 2'd3;
        tick();
        move_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("mr_ehp", enemy_hp, 100);
        chk("mr_busy", busy, 0);
        chk("mr_type", lfsr_type, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("mr_ehp2", enemy_hp, 100);
        chk("mr_php2", player_hp, 100);

        // bring player to 95, then move type 0
        do_reset();
        do_turn(4'd1, 2'd0, 2'd3);
        chk("h_php98", player_hp, 98);
        do_turn(4'd1, 2'd0, 2'd2);
        chk("h_php95", player_hp, 95);
        move_valid = 1'b1; move_type = 4'd0; roll_state = 2'd0;
        tick();
        move_valid = 1'b0;
        tick();
        chk("h_ehp", enemy_hp, 100);
`ifdef BATTLE_HEAL_EN
        chk("h_php_e1", player_hp, 100);
`else
        chk("h_php_e1", player_hp, 95);
`endif
        chk("h_etype", lfsr_type, 3);
        roll_state = 2'd1;
        tick();
`ifdef BATTLE_HEAL_EN
        chk("h_php_e2", player_hp, 97);
`else
        chk("h_php_e2", player_hp, 92);
`endif

        // strong roll on odd base: 15 + 7 = 22; enemy type 4 strong = 6
        do_turn(4'd15, 2'd2, 2'd2);
        chk("str_ehp", enemy_hp, 78);
`ifdef BATTLE_HEAL_EN
        chk("str_php", player_hp, 91);
`else
        chk("str_php", player_hp, 86);
`endif
        // turn counter wrapped: enemy type back to 1
        move_valid = 1'b1; move_type = 4'd1; roll_state = 2'd0;
        tick();
        move_valid = 1'b0;
        tick();
        chk("wrap_type", lfsr_type, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
